// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and fetch FSM encodings for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;
    localparam int FETCH_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular buffer of {instruction, pc} pairs with wrap-around pointers.
// The head entry is visible combinationally; flush empties the queue.
module instruction_fetch_unit_fetch_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_inst,
    input  logic [WIDTH-1:0] push_pc,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_inst,
    output logic [WIDTH-1:0] head_pc
);

    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= push_inst;
                pc_mem[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, drives the instruction-memory port with at
// most one outstanding request, and queues returned instructions for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int                   FIFO_DEPTH = FETCH_FIFO_DEPTH,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 readM1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 ack1,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 stall,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic [WORD_SIZE-1:0] inst_next_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] fetch_pc_next;
    logic [WORD_SIZE-1:0] address_next;
    logic                 readm1_next;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic                 room_now;
    logic                 room_after_push;

    instruction_fetch_unit_fetch_queue #(
        .WIDTH(WORD_SIZE),
        .DEPTH(FIFO_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_inst(data1),
        .push_pc  (address1),
        .pop      (pop),
        .flush    (redirect),
        .count    (count),
        .head_inst(inst),
        .head_pc  (inst_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH_IDLE;
            readM1   <= 1'b0;
            address1 <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            readM1   <= readm1_next;
            address1 <= address_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Redirect outranks everything; a request caught without its ack is drained.
    always_comb begin
        state_next    = state;
        readm1_next   = readM1;
        address_next  = address1;
        fetch_pc_next = fetch_pc;
        case (state)
            FETCH_IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end else if (room_now) begin
                    readm1_next  = 1'b1;
                    address_next = fetch_pc;
                    state_next   = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    if (ack1) begin
                        readm1_next = 1'b0;
                        state_next  = FETCH_IDLE;
                    end else begin
                        state_next  = FETCH_DRAIN;
                    end
                end else if (ack1) begin
                    fetch_pc_next = fetch_pc + 1'b1;
                    if (room_after_push) begin
                        address_next = fetch_pc + 1'b1;
                    end else begin
                        readm1_next = 1'b0;
                        state_next  = FETCH_IDLE;
                    end
                end
            end
            FETCH_DRAIN: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end
                if (ack1) begin
                    readm1_next = 1'b0;
                    state_next  = FETCH_IDLE;
                end
            end
            default: begin
                readm1_next = 1'b0;
                state_next  = FETCH_IDLE;
            end
        endcase
    end

    always_comb begin
        inst_valid      = (count != '0);
        inst_next_pc    = inst_pc + 1'b1;
        pop             = inst_valid && !stall && !redirect;
        push            = (state == FETCH_REQ) && ack1 && !redirect;
        room_now        = (int'(count) < FIFO_DEPTH);
        room_after_push = ((int'(count) + 1 - int'(pop)) < FIFO_DEPTH);
    end

endmodule
